digit_scan_controller: RTL
==========================

Name: digit_scan_controller

Overview:
Sequencer that drives the shared 4-bit-to-7-segment transmitter. It accepts a packed multi-digit word over a valid/ready handshake. It then presents one nibble at a time on data_out with start asserted, together with a one-hot digit select, and holds each digit for a programmable time followed by a blanking gap. It can rescan the last word continuously for multiplexed displays, and it pulses frame_done after each complete scan.

Parameters:
NUM_DIGITS, 4, number of nibbles per word and width of digit_sel
HOLD_CYCLES, 8, cycles start stays high per digit (0 treated as 1)
GAP_CYCLES, 2, blanking cycles after each digit (0 = no gap state)
CNT_W, 8, width of internal cycle counter; HOLD_CYCLES and GAP_CYCLES must be < 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
word_in  input  4*NUM_DIGITS  packed digits; digit 0 = bits [3:0]
word_valid  input  1  word_in valid
word_ready  output  1  controller can accept a word
repeat_en  input  1  rescan last captured word when idle
flush  input  1  synchronous abort of the current frame
data_out  output  4  nibble to transmitter data_in
start  output  1  to transmitter start
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse at end of frame

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (rst_n); all state on posedge clk.
- All outputs are registered except word_ready and busy, which decode state.
- Reset (async, any time, including mid-frame):
  - State IDLE; shadow word, loaded flag, digit index and counter cleared.
  - data_out=0, start=0, digit_sel=0, frame_done=0, busy=0, word_ready=1.
- States: IDLE, SHOW, GAP.
- IDLE: word_ready=1, busy=0.
  - word_valid=1 at edge: capture word_in into shadow, set loaded, index=0, go to SHOW.
  - Else if repeat_en=1 and loaded=1: index=0, go to SHOW with the existing shadow.
  - Else stay in IDLE.
  - A new word has priority over repeat.
- SHOW: word_ready=0, busy=1.
  - start=1, data_out=shadow[4*idx+3:4*idx], digit_sel=1<<idx.
  - Lasts exactly max(HOLD_CYCLES,1) cycles, then go to GAP; if GAP_CYCLES=0, go directly to next digit or end.
- GAP: start=0, digit_sel=0, data_out holds last nibble.
  - Lasts exactly GAP_CYCLES cycles.
- Digit advance: when idx < NUM_DIGITS-1, idx increments and the next cycle is SHOW.
- Frame end: after the last digit completes, go to IDLE. frame_done=1 for exactly the first IDLE cycle.
- Latency:
  - Handshake at edge of cycle 0 means start=1 in cycles 1..HOLD.
  - Digit k occupies cycles 1+k*(HOLD+GAP) .. k*(HOLD+GAP)+HOLD.
  - frame_done is in cycle NUM_DIGITS*(HOLD+GAP)+1, which is 41 with defaults.
- Back-to-back: word_valid high on the frame_done cycle is accepted, and the next SHOW follows with no extra bubble.
- word_valid while busy: ignored because word_ready=0. The sender holds the word; it is neither lost nor captured.
- repeat_en: sampled only in IDLE. Deasserting it mid-frame does not truncate the frame.
- flush=1 in SHOW/GAP: next cycle is IDLE with start=0 and digit_sel=0. No frame_done; shadow and loaded are retained.
- flush in IDLE: no effect. flush has priority over word capture in the same cycle.
- Counter: reloads on every state entry and never wraps within a state.
- digit_sel is never multi-hot and is zero whenever start=0.

Test Plan:
1. Reset then word 16'hA3F1, valid one cycle, defaults.
   - start high cycles 1-8 with data_out=1, digit_sel=0001; cycles 11-18 with data_out=F, sel=0010; then 3 and A.
   - frame_done at cycle 41 only; busy=1 cycles 1-40.
2. Hold word_valid high with 16'h1234 during the frame, then present 16'h5678 on the frame_done cycle.
   - 16'h1234 is not re-captured mid-frame.
   - 16'h5678 is captured at the frame_done edge; its digit 0 (8) starts the next cycle.
3. repeat_en=1 after one word 16'h0042, no further valid.
   - Frames of 2,4,0,0 repeat continuously; frame_done every 41 cycles; word_ready high only on those cycles.
4. repeat_en=1 from reset with no word ever sent.
   - Controller stays IDLE; start=0 and busy=0 indefinitely.
5. flush at cycle 15 of a frame.
   - Cycle 16 is IDLE with start=0 and digit_sel=0; frame_done never pulses.
   - With repeat_en=1, the retained word rescans from digit 0.
6. rst_n low at cycle 20 mid-SHOW, then HOLD_CYCLES=0, GAP_CYCLES=0 variant.
   - On reset, outputs go to zero immediately (no clock needed).
   - Zero-length variant: each digit is 1 cycle, there is no gap, and frame_done is at cycle NUM_DIGITS+1.

Source files
------------

// File: rtl/digit_scan_controller.sv
// Multiplexed display scan sequencer: captures a packed digit word and presents each
// nibble with start and a one-hot digit select for a hold time, then a blanking gap.
module digit_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int HOLD_CYCLES = 8,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4*NUM_DIGITS-1:0] word_in,
   input  logic                    word_valid,
   output logic                    word_ready,
   input  logic                    repeat_en,
   input  logic                    flush,
   output logic [3:0]              data_out,
   output logic                    start,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    busy,
   output logic                    frame_done
);

   localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int HOLD_EFF = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
   localparam bit HAS_GAP  = (GAP_CYCLES != 0);
   // Counters count down to zero, so load one less than the state length.
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t                  state;
   logic [4*NUM_DIGITS-1:0] shadow;
   logic                    loaded;
   logic [IDX_W-1:0]        idx;
   logic [CNT_W-1:0]        cnt;

   logic             hold_done;
   logic             digit_done;
   logic             last_digit;
   logic [IDX_W-1:0] next_idx;
   logic [3:0]       next_nibble;

   assign word_ready = (state == IDLE);
   assign busy       = (state != IDLE);

   always_comb begin
      hold_done   = (state == SHOW) && (cnt == '0);
      digit_done  = (hold_done && !HAS_GAP) || ((state == GAP) && (cnt == '0));
      last_digit  = (idx == IDX_W'(NUM_DIGITS - 1));
      next_idx    = idx + IDX_W'(1);
      next_nibble = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (next_idx == IDX_W'(i)) next_nibble = shadow[4*i +: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shadow     <= '0;
         loaded     <= 1'b0;
         idx        <= '0;
         cnt        <= '0;
         data_out   <= '0;
         start      <= 1'b0;
         digit_sel  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               // A freshly offered word wins over rescanning the old one.
               if (word_valid) begin
                  shadow    <= word_in;
                  loaded    <= 1'b1;
                  data_out  <= word_in[3:0];
                  start     <= 1'b1;
                  digit_sel <= NUM_DIGITS'(1);
                  idx       <= '0;
                  cnt       <= HOLD_LOAD;
                  state     <= SHOW;
               end else if (repeat_en && loaded) begin
                  data_out  <= shadow[3:0];
                  start     <= 1'b1;
                  digit_sel <= NUM_DIGITS'(1);
                  idx       <= '0;
                  cnt       <= HOLD_LOAD;
                  state     <= SHOW;
               end
            end
            SHOW, GAP: begin
               if (flush) begin
                  start     <= 1'b0;
                  digit_sel <= '0;
                  state     <= IDLE;
               end else if (digit_done) begin
                  if (last_digit) begin
                     start      <= 1'b0;
                     digit_sel  <= '0;
                     frame_done <= 1'b1;
                     state      <= IDLE;
                  end else begin
                     idx       <= next_idx;
                     data_out  <= next_nibble;
                     start     <= 1'b1;
                     digit_sel <= NUM_DIGITS'(1) << next_idx;
                     cnt       <= HOLD_LOAD;
                     state     <= SHOW;
                  end
               end else if (hold_done) begin
                  start     <= 1'b0;
                  digit_sel <= '0;
                  cnt       <= GAP_LOAD;
                  state     <= GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
